// File: rtl/ps2_kbd_rx_if.sv
// Host-side handshake bundle for the PS/2 keyboard receiver.
// The receiver takes the slave modport and the host or scan-code decoder takes the master.
// The bundle carries the scan-code FIFO head, its ready flag, the active-low pop strobe,
// and the two status outputs.
`timescale 1ns/1ps

interface ps2_kbd_rx_if;
  logic       nextdata_n;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic       frame_err;

  modport master (
    output nextdata_n,
    input  data,
    input  ready,
    input  overflow,
    input  frame_err
  );

  modport slave (
    input  nextdata_n,
    output data,
    output ready,
    output overflow,
    output frame_err
  );
endinterface

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver.
// The receiver oversamples ps2_clk and ps2_data in the clk domain and deframes 11-bit
// frames into 8-bit scan codes. The scan codes are buffered in a small FIFO and handed
// to the host over the ready/nextdata_n handshake.
// Optional feature: define PS2_PARITY_CHECK_EN to also reject frames with bad odd parity.
`timescale 1ns/1ps

module ps2_kbd_rx #(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ps2_clk,
  input  logic         ps2_data,
  ps2_kbd_rx_if.slave  host
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [2:0]    clk_sync;
  logic [2:0]    dat_sync;
  logic          fall;
  logic          bit_in;

  logic [3:0]    bit_cnt;
  logic [9:0]    shift_q;
  logic [TW-1:0] tmo_cnt;

  logic          stop_now;
  logic          start_ok;
  logic          stop_ok;
  logic          parity_ok;
  logic          frame_ok;
  logic          frame_bad;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   w_ptr;
  logic [AW:0]   r_ptr;
  logic [AW:0]   w_ptr_nxt;
  logic [AW:0]   r_ptr_nxt;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;

  logic          ready_q;
  logic          overflow_q;
  logic          frame_err_q;

  // Three-flop synchronisers for both PS/2 lines; they idle high out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync <= 3'b111;
      dat_sync <= 3'b111;
    end else begin
      clk_sync <= {clk_sync[1:0], ps2_clk};
      dat_sync <= {dat_sync[1:0], ps2_data};
    end
  end

  // A falling edge of the device clock is seen between sync stages 2 and 1.
  // The data bit is taken from the matching stage.
  assign fall   = clk_sync[2] & ~clk_sync[1];
  assign bit_in = dat_sync[1];

  // On the stop bit, shift_q holds {parity, d7..d0, start}. The stop bit is the live input.
  assign stop_now = fall && (bit_cnt == 4'd10);
  assign start_ok = ~shift_q[0];
  assign stop_ok  = bit_in;

`ifdef PS2_PARITY_CHECK_EN
  assign parity_ok = ^shift_q[9:1];
`else
  // The parity bit is still captured so the frame layout is identical, but it is not judged.
  logic parity_unused;
  assign parity_unused = ^shift_q[9:1];
  assign parity_ok     = 1'b1;
`endif

  assign frame_ok  = stop_now & start_ok & stop_ok & parity_ok;
  assign frame_bad = stop_now & ~(start_ok & stop_ok & parity_ok);

  // Bit counter, frame shifter and inactivity timeout that abandons a stalled partial frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt <= 4'd0;
      shift_q <= 10'd0;
      tmo_cnt <= '0;
    end else if (fall) begin
      tmo_cnt <= '0;
      if (bit_cnt == 4'd10) begin
        bit_cnt <= 4'd0;
      end else begin
        shift_q <= {bit_in, shift_q[9:1]};
        bit_cnt <= bit_cnt + 4'd1;
      end
    end else if (bit_cnt != 4'd0) begin
      if (tmo_cnt >= TW'(TIMEOUT_CYC - 1)) begin
        bit_cnt <= 4'd0;
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end else begin
      tmo_cnt <= '0;
    end
  end

  // Pointer arithmetic. ready_q tracks non-empty exactly, so a pop never underflows.
  // A pop in the same cycle frees the slot that a full FIFO would otherwise refuse.
  assign empty     = (w_ptr == r_ptr);
  assign full      = (w_ptr[AW-1:0] == r_ptr[AW-1:0]) && (w_ptr[AW] != r_ptr[AW]);
  assign pop       = ready_q & ~host.nextdata_n;
  assign push      = frame_ok & (~full | pop);
  assign drop      = frame_ok & full & ~pop;
  assign w_ptr_nxt = w_ptr + (AW+1)'(push);
  assign r_ptr_nxt = r_ptr + (AW+1)'(pop);

  // FIFO storage and pointers. The memory clears on reset, so data reads 00 before the first push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= 8'h00;
      end
      w_ptr <= '0;
      r_ptr <= '0;
    end else begin
      if (push) begin
        mem[w_ptr[AW-1:0]] <= shift_q[8:1];
      end
      w_ptr <= w_ptr_nxt;
      r_ptr <= r_ptr_nxt;
    end
  end

  // Registered status: ready follows the updated pointers, overflow is sticky until a pop,
  // and frame_err is a single-cycle pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_q     <= 1'b0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      ready_q     <= (w_ptr_nxt != r_ptr_nxt);
      frame_err_q <= frame_bad;
      if (drop) begin
        overflow_q <= 1'b1;
      end else if (pop && !(frame_ok && full)) begin
        overflow_q <= 1'b0;
      end
    end
  end

  assign host.data      = mem[r_ptr[AW-1:0]];
  assign host.ready     = ready_q;
  assign host.overflow  = overflow_q;
  assign host.frame_err = frame_err_q;

  // empty is kept for readability of the full/empty pair; ready_q is its registered inverse.
  logic empty_unused;
  assign empty_unused = empty;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Self-checking bench for ps2_kbd_rx.
// A PS/2 device model drives frames, and the expected scan codes are queued as each
// frame is issued. A monitor pops from the queue and compares on every host pop.
`timescale 1ns/1ps

module tb_ps2_kbd_rx;

  logic       clk      = 1'b0;
  logic       rst      = 1'b0;
  logic       ps2_clk  = 1'b1;
  logic       ps2_data = 1'b1;

  int         host_mode  = 0;
  int         n_pass     = 0;
  int         n_total    = 0;
  int         err_cycles = 0;
  logic [7:0] exp_q[$];

  ps2_kbd_rx_if host_if();

  ps2_kbd_rx dut (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .host     (host_if)
  );

  // 10 ns system clock
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // PS/2 device model: send the first nbits of a frame, with an optional bad stop or parity bit.
  task automatic apply_stimulus(input logic [7:0] d, input logic bad_stop,
                                input logic bad_par, input int nbits);
    logic [10:0] f;
    f = {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      wait_clks(5);
      ps2_clk = 1'b0;
      wait_clks(10);
      ps2_clk = 1'b1;
      wait_clks(5);
    end
    ps2_data = 1'b1;
    wait_clks(20);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_output("drain_queue_empty", exp_q.size(), 0);
  endtask

  // Host driver: 0 = hold nextdata_n high, 1 = pop whenever ready, 2 = hold nextdata_n low.
  initial begin
    host_if.nextdata_n = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (host_mode)
        1:       host_if.nextdata_n = ~host_if.ready;
        2:       host_if.nextdata_n = 1'b0;
        default: host_if.nextdata_n = 1'b1;
      endcase
    end
  end

  // Scoreboard monitor: a pop takes effect at the next posedge, so compare the head now.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst && host_if.ready && !host_if.nextdata_n) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("[TB] FAIL unexpected_pop: got %0h, expected no entry", host_if.data);
        end else begin
          e = exp_q.pop_front();
          check_output("pop_data", host_if.data, e);
        end
      end
      if (rst && host_if.frame_err) begin
        err_cycles++;
      end
    end
  end

  // Watchdog
  initial begin
    #800000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] seq1 [6];
    int         err0;
    seq1 = '{8'h1C, 8'hF0, 8'h1C, 8'h1B, 8'hF0, 8'h1B};

    // Reset values
    wait_clks(3);
    @(negedge clk);
    check_output("reset_ready", host_if.ready, 0);
    check_output("reset_overflow", host_if.overflow, 0);
    check_output("reset_frame_err", host_if.frame_err, 0);
    check_output("reset_data", host_if.data, 8'h00);
    rst = 1'b1;
    wait_clks(5);

    // Test 1: key press/release sequence with an eager host
    $display("[TB] test 1: make/break sequence");
    host_mode = 1;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(seq1[i]);
      apply_stimulus(seq1[i], 1'b0, 1'b0, 11);
    end
    wait_drain(200);
    @(negedge clk);
    check_output("t1_overflow", host_if.overflow, 0);
    check_output("t1_frame_err_cycles", err_cycles, 0);

    // Test 2: overflow with nine frames and no host pops
    $display("[TB] test 2: overflow");
    host_mode = 0;
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) exp_q.push_back(8'(i));
      apply_stimulus(8'(i), 1'b0, 1'b0, 11);
    end
    @(negedge clk);
    check_output("t2_ready_full", host_if.ready, 1);
    check_output("t2_overflow_set", host_if.overflow, 1);
    host_mode = 2;
    repeat (2) @(negedge clk);
    check_output("t2_overflow_clr", host_if.overflow, 0);
    check_output("t2_ready_after_pop", host_if.ready, 1);
    wait_drain(50);
    @(negedge clk);
    check_output("t2_ready_empty", host_if.ready, 0);
    host_mode = 0;
    wait_clks(3);

    // Test 3: bad stop bit
    $display("[TB] test 3: framing error");
    err0 = err_cycles;
    apply_stimulus(8'h1C, 1'b1, 1'b0, 11);
    @(negedge clk);
    check_output("t3_frame_err_cycles", err_cycles - err0, 1);
    check_output("t3_ready", host_if.ready, 0);

    // Test 4: even parity on 1C
    $display("[TB] test 4: parity");
    err0 = err_cycles;
`ifdef PS2_PARITY_CHECK_EN
    apply_stimulus(8'h1C, 1'b0, 1'b1, 11);
    @(negedge clk);
    check_output("t4_frame_err_cycles", err_cycles - err0, 1);
    check_output("t4_ready", host_if.ready, 0);
`else
    host_mode = 1;
    exp_q.push_back(8'h1C);
    apply_stimulus(8'h1C, 1'b0, 1'b1, 11);
    wait_drain(200);
    @(negedge clk);
    check_output("t4_frame_err_cycles", err_cycles - err0, 0);
    host_mode = 0;
`endif

    // Test 5: partial frame abandoned by the timeout
    $display("[TB] test 5: timeout");
    err0 = err_cycles;
    host_mode = 1;
    apply_stimulus(8'h55, 1'b0, 1'b0, 5);
    wait_clks(20100);
    exp_q.push_back(8'h2A);
    apply_stimulus(8'h2A, 1'b0, 1'b0, 11);
    wait_drain(200);
    wait_clks(3);
    @(negedge clk);
    check_output("t5_frame_err_cycles", err_cycles - err0, 0);
    check_output("t5_ready", host_if.ready, 0);
    host_mode = 0;

    // Test 6: reset in the middle of a frame
    $display("[TB] test 6: reset mid-frame");
    apply_stimulus(8'h77, 1'b0, 1'b0, 4);
    @(negedge clk);
    rst = 1'b0;
    wait_clks(3);
    @(negedge clk);
    check_output("t6_ready_in_reset", host_if.ready, 0);
    check_output("t6_data_in_reset", host_if.data, 8'h00);
    rst = 1'b1;
    wait_clks(5);
    apply_stimulus(8'h33, 1'b0, 1'b0, 11);
    @(negedge clk);
    check_output("t6_ready", host_if.ready, 1);
    check_output("t6_data", host_if.data, 8'h33);
    check_output("t6_overflow", host_if.overflow, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
